// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator and pixel output stage. A programmable
//   divider derives a one-clk pixel strobe from clk. The h/v counters walk the
//   mode timing (active, front porch, sync, back porch). Sync and blank are
//   delayed to line up with a renderer of fixed latency and registered together
//   with the colour for the DAC. Start/stop only take effect at frame
//   boundaries.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   enable          run request; sampled on a tick in IDLE and on the last
//                   pixel of the frame in RUN
//   pixel_color     {R,G,B}, valid PIPE_DELAY pixel periods after x/y
//   pix_en          one-clk pixel strobe (RUN only)
//   x, y            current hcount / vcount
//   active          pixel (x,y) lies in the visible area
//   sof, eol        start-of-frame / end-of-visible-line pulses with pix_en
//   VGA_*           registered DAC colour and control outputs
module vga_timing_gen #(
  parameter int unsigned COLOR_W       = 8,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned PIPE_DELAY    = 2,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned X_W     = $clog2(H_TOTAL),
  localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   pixel_color,
  output logic                   pix_en,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic                   active,
  output logic                   sof,
  output logic                   eol,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_n,
  output logic                   VGA_SYNC_n
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  // Counter constants are one bit wider than the counters so that a sync end
  // equal to the total (zero back porch) still fits.
  localparam logic [X_W:0] H_LAST  = (X_W+1)'(H_TOTAL - 1);
  localparam logic [X_W:0] H_ACT   = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0] H_EOL   = (X_W+1)'(H_ACTIVE - 1);
  localparam logic [X_W:0] HS_BEG  = (X_W+1)'(H_ACTIVE + H_FP);
  localparam logic [X_W:0] HS_END  = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W:0] V_LAST  = (Y_W+1)'(V_TOTAL - 1);
  localparam logic [Y_W:0] V_ACT   = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] VS_BEG  = (Y_W+1)'(V_ACTIVE + V_FP);
  localparam logic [Y_W:0] VS_END  = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Sync lines idle at the opposite of their asserted level.
  localparam logic HS_OFF = HS_ACTIVE_LOW;
  localparam logic VS_OFF = VS_ACTIVE_LOW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nx;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [X_W-1:0]         hcount;
  logic [Y_W-1:0]         vcount;
  logic [X_W:0]           hx;
  logic [Y_W:0]           vy;
  logic                   line_last;
  logic                   frame_last;
  logic                   stop;
  logic                   raw_hs, raw_vs, raw_bn;
  logic [PIPE_DELAY:0]    hs_sr, vs_sr, bn_sr;
  logic [PIPE_DELAY+1:0]  hs_sh, vs_sh, bn_sh;
  logic [3*COLOR_W-1:0]   rgb_q;

  // Pixel clock divider, free-running after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign VGA_CLK = (div_cnt >= DIV_HALF);

  assign hx         = {1'b0, hcount};
  assign vy         = {1'b0, vcount};
  assign line_last  = (hx == H_LAST);
  assign frame_last = line_last && (vy == V_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tick && enable)                state_nx = RUN;
      RUN:  if (tick && frame_last && !enable) state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    pix_en = 1'b0;
    active = 1'b0;
    if (state == RUN) begin
      pix_en = tick;
      active = (hx < H_ACT) && (vy < V_ACT);
    end
    sof  = pix_en && (hcount == '0) && (vcount == '0);
    eol  = pix_en && (hx == H_EOL) && (vy < V_ACT);
    stop = pix_en && frame_last && !enable;
  end

  // Counters only move on pix_en; the stop pixel is also the wrap pixel, so
  // they land on 0,0 without a separate clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (line_last) begin
        hcount <= '0;
        vcount <= (vy == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign x = hcount;
  assign y = vcount;

  assign raw_hs = ((hx >= HS_BEG) && (hx < HS_END)) ^ HS_ACTIVE_LOW;
  assign raw_vs = ((vy >= VS_BEG) && (vy < VS_END)) ^ VS_ACTIVE_LOW;
  assign raw_bn = (hx < H_ACT) && (vy < V_ACT);

  // Each *_sr holds PIPE_DELAY delay stages plus the output register in its
  // top bit. Prepending the raw value gives the shifted image; its bit
  // PIPE_DELAY is the delayed blank that gates the colour load, and its top
  // bit is the current output.
  assign hs_sh = {hs_sr, raw_hs};
  assign vs_sh = {vs_sr, raw_vs};
  assign bn_sh = {bn_sr, raw_bn};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sr <= {(PIPE_DELAY+1){HS_OFF}};
      vs_sr <= {(PIPE_DELAY+1){VS_OFF}};
      bn_sr <= '0;
      rgb_q <= '0;
    end else if (stop) begin
      // Leaving RUN drops the back-porch pixels still in flight.
      hs_sr <= {(PIPE_DELAY+1){HS_OFF}};
      vs_sr <= {(PIPE_DELAY+1){VS_OFF}};
      bn_sr <= '0;
      rgb_q <= '0;
    end else if (pix_en) begin
      hs_sr <= hs_sh[PIPE_DELAY:0];
      vs_sr <= vs_sh[PIPE_DELAY:0];
      bn_sr <= bn_sh[PIPE_DELAY:0];
      rgb_q <= bn_sh[PIPE_DELAY] ? pixel_color : '0;
    end
  end

  assign VGA_HS      = hs_sh[PIPE_DELAY+1];
  assign VGA_VS      = vs_sh[PIPE_DELAY+1];
  assign VGA_BLANK_n = bn_sh[PIPE_DELAY+1];
  assign VGA_R       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign VGA_G       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign VGA_B       = rgb_q[COLOR_W-1:0];
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small mode (H 8/2/3/2, V 4/1/2/1).
//   dut_a: CLK_DIV=2, active-low syncs, colour pattern {x,y,A5}
//   dut_p: same mode, active-high syncs
//   dut_c: CLK_DIV=4, used for the asynchronous mid-line reset
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_c = 1'b1;
  logic en_a = 1'b1, en_p = 1'b1, en_c = 1'b1;
  logic [23:0] pc_a = '0, d1 = '0, d2 = '0;
  logic [23:0] pc_zero = '0;

  logic       pix_en_a, active_a, sof_a, eol_a, vclk_a, hs_a, vs_a, bn_a, sn_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic [7:0] r_a, g_a, b_a;

  logic       pix_en_p, active_p, sof_p, eol_p, vclk_p, hs_p, vs_p, bn_p, sn_p;
  logic [3:0] x_p;
  logic [2:0] y_p;
  logic [7:0] r_p, g_p, b_p;

  logic       pix_en_c, active_c, sof_c, eol_c, vclk_c, hs_c, vs_c, bn_c, sn_c;
  logic [3:0] x_c;
  logic [2:0] y_c;
  logic [7:0] r_c, g_c, b_c;

  vga_timing_gen #(
    .COLOR_W(8), .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .PIPE_DELAY(2)
  ) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .pixel_color(pc_a),
    .pix_en(pix_en_a), .x(x_a), .y(y_a), .active(active_a), .sof(sof_a), .eol(eol_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_CLK(vclk_a), .VGA_HS(hs_a),
    .VGA_VS(vs_a), .VGA_BLANK_n(bn_a), .VGA_SYNC_n(sn_a)
  );

  vga_timing_gen #(
    .COLOR_W(8), .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0), .PIPE_DELAY(2)
  ) dut_p (
    .clk(clk), .reset(rst_a), .enable(en_p), .pixel_color(pc_zero),
    .pix_en(pix_en_p), .x(x_p), .y(y_p), .active(active_p), .sof(sof_p), .eol(eol_p),
    .VGA_R(r_p), .VGA_G(g_p), .VGA_B(b_p), .VGA_CLK(vclk_p), .VGA_HS(hs_p),
    .VGA_VS(vs_p), .VGA_BLANK_n(bn_p), .VGA_SYNC_n(sn_p)
  );

  vga_timing_gen #(
    .COLOR_W(8), .CLK_DIV(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .PIPE_DELAY(2)
  ) dut_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .pixel_color(pc_zero),
    .pix_en(pix_en_c), .x(x_c), .y(y_c), .active(active_c), .sof(sof_c), .eol(eol_c),
    .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c), .VGA_CLK(vclk_c), .VGA_HS(hs_c),
    .VGA_VS(vs_c), .VGA_BLANK_n(bn_c), .VGA_SYNC_n(sn_c)
  );

  // Renderer stand-in: colour of pixel (x,y) presented two pixel periods later,
  // updated mid-cycle so it is stable at the loading edge.
  always @(negedge clk) begin
    if (pix_en_a === 1'b1) begin
      pc_a = d2;
      d2   = d1;
      d1   = {4'b0, x_a, 5'b0, y_a, 8'hA5};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int found, first, pe_cnt;
  int p, px, py, q, qx, qy;
  logic pe, hl, vl, bn;
  logic [23:0] rgb, rgb5;
  logic bn4, bn5;
  int bad_ctl, bad_a, bad_p, pix_cnt, sof_cnt, max_x;
  int hs_low_a, vs_low_a, hs_high_p, vs_high_p;

  initial begin
    bad_ctl = 0; bad_a = 0; bad_p = 0; pix_cnt = 0; sof_cnt = 0; max_x = 0;
    hs_low_a = 0; vs_low_a = 0; hs_high_p = 0; vs_high_p = 0;
    bn4 = 1'bx; bn5 = 1'bx; rgb5 = 'x;

    // Reset state.
    repeat (3) step();
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_pix_en", pix_en_a, 0);
    chk("rst_sof", sof_a, 0);
    chk("rst_eol", eol_a, 0);
    chk("rst_active", active_a, 0);
    chk("rst_vga_clk", vclk_a, 0);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_blank_n", bn_a, 0);
    chk("rst_rgb", {r_a, g_a, b_a}, 0);
    chk("sync_n", sn_a, 0);
    chk("rst_hs_pos", hs_p, 0);
    chk("rst_vs_pos", vs_p, 0);

    @(negedge clk);
    rst_a = 1'b0;
    rst_c = 1'b0;

    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sof_a === 1'b1) begin found = 1; break; end
    end
    chk("first_sof_seen", found, 1);

    // Two frames from the first sof: n counts clk cycles, pixel strobes on even n.
    // x/y for pixel p are visible in cycles 2p-1 and 2p; outputs lag 3 pixels.
    for (int n = 0; n < 480; n++) begin
      p  = (n + 1) / 2;
      px = p % 15;
      py = (p / 15) % 8;
      pe = (n % 2 == 0);
      if (pix_en_a !== pe || vclk_a !== pe || sof_a !== (pe && n % 240 == 0) ||
          eol_a !== (pe && px == 7 && py < 4) || active_a !== (px < 8 && py < 4) ||
          x_a !== 4'(px) || y_a !== 3'(py))
        bad_ctl++;
      if (n < 240) begin
        pix_cnt += int'(pix_en_a);
        sof_cnt += int'(sof_a);
        if (int'(x_a) > max_x) max_x = int'(x_a);
      end
      if (n < 5) begin
        qx = 0; qy = 0; hl = 1'b0; vl = 1'b0; bn = 1'b0;
      end else begin
        q  = (n - 5) / 2;
        qx = q % 15;
        qy = (q / 15) % 8;
        hl = (qx >= 10 && qx < 13);
        vl = (qy >= 5 && qy < 7);
        bn = (qx < 8 && qy < 4);
      end
      rgb = bn ? {8'(qx), 8'(qy), 8'hA5} : 24'h0;
      if (hs_a !== !hl || vs_a !== !vl || bn_a !== bn || {r_a, g_a, b_a} !== rgb) bad_a++;
      if (hs_p !== hl || vs_p !== vl || bn_p !== bn) bad_p++;
      if (n >= 5 && n < 245) begin
        hs_low_a  += int'(hs_a === 1'b0);
        vs_low_a  += int'(vs_a === 1'b0);
        hs_high_p += int'(hs_p === 1'b1);
        vs_high_p += int'(vs_p === 1'b1);
      end
      if (n == 4) bn4 = bn_a;
      if (n == 5) begin bn5 = bn_a; rgb5 = {r_a, g_a, b_a}; end
      step();
    end
    chk("counters_per_cycle", bad_ctl, 0);
    chk("outputs_per_cycle", bad_a, 0);
    chk("outputs_pos_per_cycle", bad_p, 0);
    chk("pixels_per_frame", pix_cnt, 120);
    chk("sof_per_frame", sof_cnt, 1);
    chk("hcount_max", max_x, 14);
    chk("hs_low_clks", hs_low_a, 48);
    chk("vs_low_clks", vs_low_a, 60);
    chk("hs_high_clks_pos", hs_high_p, 48);
    chk("vs_high_clks_pos", vs_high_p, 60);
    chk("blank_n_before_first", bn4, 0);
    chk("blank_n_first", bn5, 1);
    chk("rgb_first", rgb5, 24'h0000A5);

    // Stop request mid-frame: the frame must finish before IDLE.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (y_a == 3'd2) begin en_a = 1'b0; found = 1; break; end
      step();
    end
    chk("stop_requested_at_y2", found, 1);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (pix_en_a === 1'b1 && x_a == 4'd14 && y_a == 3'd7) begin found = 1; break; end
    end
    chk("last_pixel_reached", found, 1);
    step();
    chk("idle_x", x_a, 0);
    chk("idle_y", y_a, 0);
    chk("idle_active", active_a, 0);
    chk("idle_hs", hs_a, 1);
    chk("idle_vs", vs_a, 1);
    chk("idle_blank_n", bn_a, 0);
    chk("idle_rgb", {r_a, g_a, b_a}, 0);
    pe_cnt = 0;
    repeat (20) begin
      step();
      pe_cnt += int'(pix_en_a === 1'b1);
    end
    chk("idle_no_pix_en", pe_cnt, 0);

    // Restart: first strobe is pixel (0,0).
    en_a = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pix_en_a === 1'b1) begin found = 1; break; end
    end
    chk("restart_pix_en", found, 1);
    chk("restart_sof", sof_a, 1);
    chk("restart_x", x_a, 0);
    chk("restart_y", y_a, 0);

    // Asynchronous reset mid-line on the CLK_DIV=4 instance.
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (x_c == 4'd5 && vclk_c === 1'b1) begin found = 1; break; end
    end
    chk("c_reached_x5", found, 1);
    #2;
    rst_c = 1'b1;
    #1;
    chk("async_x", x_c, 0);
    chk("async_y", y_c, 0);
    chk("async_pix_en", pix_en_c, 0);
    chk("async_active", active_c, 0);
    chk("async_vga_clk", vclk_c, 0);
    chk("async_hs", hs_c, 1);
    chk("async_vs", vs_c, 1);
    chk("async_blank_n", bn_c, 0);
    chk("async_rgb", {r_c, g_c, b_c}, 0);

    // Released at a falling edge: transition tick ends at the 4th rising edge,
    // pixel (0,0) strobes in the cycle ending at the 8th, seen after edge 7.
    @(negedge clk);
    rst_c = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first == 0 && sof_c === 1'b1) first = k;
    end
    chk("sof_edges_after_reset", first, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage, successor to the fixed 640x480 counter block. It derives a pixel strobe from the system clock with a programmable divider and generates h/v counters for arbitrary mode timing with selectable sync polarity. It exposes pixel coordinates to the frame renderer, re-aligns sync and blank with a renderer of fixed latency, and supports clean start/stop at frame boundaries. It sits between the renderer (sprite/tile logic) and the DAC pins.

## Interface
- COLOR_W, 8, bits per colour channel
- CLK_DIV, 2, clk cycles per pixel; legal range 2..16
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels; H_TOTAL = sum
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines; V_TOTAL = sum
- HS_ACTIVE_LOW / VS_ACTIVE_LOW, 1 / 1, sync polarity
- PIPE_DELAY, 2, renderer latency in pixel periods, 0..7
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request, acted on only at frame boundaries
- pixel_color  in  3*COLOR_W  {R,G,B}, valid PIPE_DELAY pixel periods after x/y
- pix_en  out  1  one-clk pixel strobe, RUN state only
- x  out  $clog2(H_TOTAL)  current hcount
- y  out  $clog2(V_TOTAL)  current vcount
- active  out  1  x<H_ACTIVE && y<V_ACTIVE
- sof  out  1  pulse with pix_en at x=0,y=0
- eol  out  1  pulse with pix_en at x=H_ACTIVE-1, y<V_ACTIVE
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  registered colour
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1 each  DAC controls

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 continuously after reset; tick = (div_cnt==CLK_DIV-1).
- VGA_CLK = (div_cnt >= CLK_DIV/2): registered outputs change on the falling half, so DAC samples on the rising edge mid-pixel.
- States IDLE, RUN. Reset -> IDLE.
- IDLE: x=y=0, pix_en/sof/eol=0, VGA outputs at inactive values. On a tick with enable=1 -> RUN; the next tick is pixel (0,0).
- RUN: pix_en=tick. On pix_en, hcount wraps H_TOTAL-1 -> 0; vcount advances on hcount wrap and wraps V_TOTAL-1 -> 0.
- Stop: on the pix_en at (H_TOTAL-1, V_TOTAL-1) with enable=0 -> IDLE. Deassertion mid-frame finishes the frame.
- Horizontal order: active [0,H_ACTIVE), FP, sync [H_ACTIVE+H_FP, +H_SYNC), BP. Vertical uses the same order in lines.
- Raw hs/vs/blank are computed from hcount/vcount. They pass through a PIPE_DELAY-stage shift register advanced on pix_en, then the output register.
- Output register loads on pix_en: RGB = pixel_color when delayed blank_n=1, else 0. HS/VS/BLANK_n load in the same register.
- VGA outputs therefore lag x/y by PIPE_DELAY+1 pixel periods, with colour aligned to its sync/blank.
- On the IDLE transition, the shift register and output register clear to inactive. Only vertical BP is discarded.
- VGA_SYNC_n is constant 0.

## Timing
- Reset values:
  - div_cnt=0 (VGA_CLK=0), x=y=0, pix_en=sof=eol=active=0
  - RGB=0, BLANK_n=0
  - HS = HS_ACTIVE_LOW ? 1 : 0; VS likewise
- Reset assertion at any time returns to IDLE asynchronously; no partial frame resumes.
- pix_en period = CLK_DIV clk cycles. Line = H_TOTAL*CLK_DIV clks. Frame = H_TOTAL*V_TOTAL*CLK_DIV clks.
- sof/eol are one clk wide and coincide with pix_en.
- x/y/active change on the clk edge of pix_en and hold for CLK_DIV cycles.
- Counter widths: no overflow for any legal parameter set. Comparisons are unsigned.
- When the stop and wrap conditions coincide, the block goes to IDLE; the wrapped x/y is 0,0 either way.

## Test plan
- Small mode: H 8/2/3/2, V 4/1/2/1, CLK_DIV=2, PIPE_DELAY=2, enable=1 from reset.
  - Required: pix_en every 2 clks, hcount 0..14, 120 pixels/frame, frame = 240 clks, sof once per frame.
- Same mode, sync.
  - Required: VGA_HS low exactly 6 clks per line, falling 3 pix_en after x reaches 10.
  - Required: VGA_VS low for 2 lines (60 clks), starting 3 pixel periods after y reaches 5.
- Alignment: pixel_color = {x,y,8'hA5}, delayed by 2 ticks in the bench.
  - Required: the first non-zero RGB coincides with the first BLANK_n=1 and equals the (0,0) colour; RGB=0 whenever BLANK_n=0.
- Polarity: HS_ACTIVE_LOW=0, VS_ACTIVE_LOW=0.
  - Required: reset values HS=VS=0; pulses high with identical widths.
- Stop/start: drop enable at y=2.
  - Required: frame completes to (14,7), then IDLE with outputs inactive.
  - Re-assert: the first pix_en after the transition tick has sof=1, x=0, y=0.
- Reset mid-line at x=5, CLK_DIV=4.
  - Required: all outputs take reset values immediately without waiting for clk.
  - After release with enable=1: the first sof occurs 8 clks later.
